regfile_write_arbiter: RTL

Shares the register file's single write port between two writeback sources: the main pipeline writeback stage and the long-latency mult/div unit. The pipeline has fixed priority and is never back-pressured in a normal cycle. Mult/div results are held in a one-entry buffer with a valid/ready handshake. A starvation counter forces a one-cycle pipeline stall so a buffered result always retires. The block drives the register file write port directly and exposes the pending entry for hazard detection.

---
 rtl/regfile_write_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between the pipeline writeback stage
// and a one-entry mult/div result buffer, with a starvation-driven pipeline stall.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        md_valid,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        pipe_stall,
  output logic        md_pend,
  output logic [4:0]  md_pend_reg,
  output logic        md_drop
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    STALL
  } stateT;

  localparam logic [3:0] starveLimit = 4'(STARVE_LIMIT);

  stateT       state;
  logic        bufValid;
  logic [4:0]  bufReg;
  logic [31:0] bufData;
  logic [3:0]  starveCnt;

  logic       pipeWrite;
  logic       conflict;
  logic       blocked;
  logic       retire;
  logic       acceptKeep;
  logic [3:0] starveNext;

  assign md_ready    = !bufValid && !ctrl_reset;
  assign md_pend     = bufValid;
  assign md_pend_reg = bufValid ? bufReg : 5'd0;

  // A pipeline write to register 0 is a no-op and leaves the port free.
  assign pipeWrite  = pipe_valid && (pipe_reg != 5'd0);
  assign conflict   = bufValid && pipeWrite && (pipe_reg == bufReg);
  assign blocked    = bufValid && pipeWrite && !conflict;
  assign retire     = bufValid && !pipeWrite;
  assign acceptKeep = md_valid && md_ready && (md_reg != 5'd0);
  assign starveNext = (starveCnt == 4'hF) ? starveCnt : starveCnt + 4'd1;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state            <= IDLE;
      bufValid         <= 1'b0;
      bufReg           <= 5'd0;
      bufData          <= 32'd0;
      starveCnt        <= 4'd0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
      pipe_stall       <= 1'b0;
      md_drop          <= 1'b0;
    end else begin
      md_drop <= conflict;

      if (pipeWrite) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= pipe_reg;
        data_writeReg    <= pipe_data;
      end else if (retire) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= bufReg;
        data_writeReg    <= bufData;
      end else begin
        ctrl_writeEnable <= 1'b0;
        ctrl_writeReg    <= 5'd0;
        data_writeReg    <= 32'd0;
      end

      // Acceptance only happens into an empty buffer, so it never overlaps retirement.
      if (retire || conflict) begin
        bufValid <= 1'b0;
      end else if (acceptKeep) begin
        bufValid <= 1'b1;
        bufReg   <= md_reg;
        bufData  <= md_data;
      end

      case (state)
        IDLE: begin
          starveCnt  <= 4'd0;
          pipe_stall <= 1'b0;
          if (acceptKeep) begin
            state <= PEND;
          end
        end
        PEND: begin
          if (retire || conflict) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
          end else if (blocked) begin
            starveCnt <= starveNext;
            if (starveNext >= starveLimit) begin
              state      <= STALL;
              pipe_stall <= 1'b1;
            end
          end
        end
        STALL: begin
          // Stay stalled until the entry leaves, even if upstream ignores the stall.
          if (retire || conflict) begin
            state      <= IDLE;
            starveCnt  <= 4'd0;
            pipe_stall <= 1'b0;
          end else if (blocked) begin
            starveCnt <= starveNext;
          end
        end
        default: begin
          state      <= IDLE;
          starveCnt  <= 4'd0;
          pipe_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
